// File: rtl/cv32e40p_vreg_pkg.sv
// Shared types, default sizes and helpers for the CNN vector register file.
// Contents:
//   vreg_ld_state_e  : load sequencer states (IDLE, COLLECT, COMMIT)
//   VREG_*           : default geometry (16 regs x 4 lanes x 32 bits)
//   vreg_expand_mask : widens a per-lane mask to a per-bit mask
package cv32e40p_vreg_pkg;

    localparam int unsigned VREG_NUM_REGS  = 16;
    localparam int unsigned VREG_LANES     = 4;
    localparam int unsigned VREG_LANE_W    = 32;

    // Upper bounds for the mask helper; instances must stay within these.
    localparam int unsigned VREG_MAX_LANES = 16;
    localparam int unsigned VREG_MAX_BITS  = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } vreg_ld_state_e;

    // Lane mask -> bit mask. The result is LSB-aligned; callers truncate to
    // lanes*lane_w. Built with shifts so it folds away for constant geometry.
    function automatic logic [VREG_MAX_BITS-1:0] vreg_expand_mask(
        input logic [VREG_MAX_LANES-1:0] mask,
        input int unsigned               lanes,
        input int unsigned               lane_w
    );
        logic [VREG_MAX_BITS-1:0]  res;
        logic [VREG_MAX_BITS-1:0]  lane_ones;
        logic [VREG_MAX_LANES-1:0] m;
        res       = '0;
        lane_ones = ~({VREG_MAX_BITS{1'b1}} << lane_w);
        m         = mask;
        for (int unsigned l = 0; l < VREG_MAX_LANES; l++) begin
            if ((l < lanes) && m[0]) begin
                res = res | (lane_ones << (l * lane_w));
            end
            m = m >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_vreg_ld_assembler.sv
// Beat-serial load sequencer: gathers LANES beats from the LSU into one vector
// and presents it for a single-cycle commit.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   ld_start_i         : load request (taken only in IDLE)
//   ld_addr_i          : destination register, latched on acceptance
//   ld_beat_valid_i/   : LSU beat handshake and payload, lane 0 first
//   ld_beat_data_i
//   ld_ready_o         : sequencer idle
//   commit_o           : high for the single COMMIT cycle
//   commit_addr_o      : latched destination register
//   commit_data_o      : assembled vector, lane i at [i*LANE_W +: LANE_W]
module cv32e40p_vreg_ld_assembler
    import cv32e40p_vreg_pkg::*;
#(
    parameter int unsigned LANES  = VREG_LANES,
    parameter int unsigned LANE_W = VREG_LANE_W,
    parameter int unsigned AW     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_start_i,
    input  logic [AW-1:0]           ld_addr_i,
    input  logic                    ld_beat_valid_i,
    input  logic [LANE_W-1:0]       ld_beat_data_i,
    output logic                    ld_ready_o,
    output logic                    commit_o,
    output logic [AW-1:0]           commit_addr_o,
    output logic [LANES*LANE_W-1:0] commit_data_o
);

    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    vreg_ld_state_e                 state_q, state_d;
    logic [CW-1:0]                  cnt_q,   cnt_d;
    logic [AW-1:0]                  addr_q,  addr_d;
    logic [LANES-1:0][LANE_W-1:0]   buf_q,   buf_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic; beats outside COLLECT (including the start cycle) are dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    state_d = COLLECT;
                    addr_d  = ld_addr_i;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                if (ld_beat_valid_i) begin
                    buf_d[cnt_q] = ld_beat_data_i;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CW'(LANES - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ld_ready_o    = (state_q == IDLE);
    assign commit_o      = (state_q == COMMIT);
    assign commit_addr_o = addr_q;
    assign commit_data_o = buf_q;

endmodule

// File: rtl/cv32e40p_vreg_file_ld.sv
// Vector register file for the CNN extension: NUM_REGS x (LANES x LANE_W),
// three combinational read ports, a lane-masked ALU write port, a beat-serial
// load port and a per-register busy scoreboard for decode stalls.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   alu_we/waddr/wdata/wmask      : ALU write; unmasked lanes keep their value
//   ld_start/ld_addr/ld_ready     : load request handshake
//   ld_beat_valid/ld_beat_data    : LSU beats, lane 0 first
//   ld_done                       : pulse in the load commit cycle
//   wr_conflict                   : pulse when an ALU write loses to a commit
//   raddrN/rdataN/rbusyN (N=1..3) : read ports with busy status
module cv32e40p_vreg_file_ld
    import cv32e40p_vreg_pkg::*;
#(
    parameter int unsigned NUM_REGS = VREG_NUM_REGS,
    parameter int unsigned LANES    = VREG_LANES,
    parameter int unsigned LANE_W   = VREG_LANE_W,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_we,
    input  logic [AW-1:0]           alu_waddr,
    input  logic [LANES*LANE_W-1:0] alu_wdata,
    input  logic [LANES-1:0]        alu_wmask,
    input  logic                    ld_start,
    input  logic [AW-1:0]           ld_addr,
    output logic                    ld_ready,
    input  logic                    ld_beat_valid,
    input  logic [LANE_W-1:0]       ld_beat_data,
    output logic                    ld_done,
    output logic                    wr_conflict,
    input  logic [AW-1:0]           raddr1,
    input  logic [AW-1:0]           raddr2,
    input  logic [AW-1:0]           raddr3,
    output logic [LANES*LANE_W-1:0] rdata1,
    output logic [LANES*LANE_W-1:0] rdata2,
    output logic [LANES*LANE_W-1:0] rdata3,
    output logic                    rbusy1,
    output logic                    rbusy2,
    output logic                    rbusy3
);

    localparam int unsigned DW = LANES * LANE_W;

    logic [DW-1:0]       mem_q [NUM_REGS];
    logic [DW-1:0]       mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                commit;
    logic [AW-1:0]       commit_addr;
    logic [DW-1:0]       commit_data;
    logic                commit_hit;
    logic                alu_do;
    logic [DW-1:0]       alu_bmask;

    logic [AW-1:0]       raddr_c [3];
    logic [DW-1:0]       rdata_c [3];
    logic [2:0]          rbusy_c;

    cv32e40p_vreg_ld_assembler #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .AW     (AW)
    ) u_ld_asm (
        .clk             (clk),
        .rst             (rst),
        .ld_start_i      (ld_start),
        .ld_addr_i       (ld_addr),
        .ld_beat_valid_i (ld_beat_valid),
        .ld_beat_data_i  (ld_beat_data),
        .ld_ready_o      (ld_ready),
        .commit_o        (commit),
        .commit_addr_o   (commit_addr),
        .commit_data_o   (commit_data)
    );

    assign ld_done   = commit;
    assign alu_bmask = DW'(vreg_expand_mask(VREG_MAX_LANES'(alu_wmask), LANES, LANE_W));

    // Write arbitration: a commit to an out-of-range register is discarded;
    // on a same-register collision the load wins and the ALU write is dropped.
    always_comb begin
        commit_hit  = commit && (32'(commit_addr) < NUM_REGS);
        wr_conflict = commit_hit && alu_we && (alu_waddr == commit_addr);
        alu_do      = alu_we && (32'(alu_waddr) < NUM_REGS) && !wr_conflict;
    end

    // Post-edge register image; also feeds the bypass path
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            mem_d[r] = mem_q[r];
            if (alu_do && (alu_waddr == AW'(r))) begin
                mem_d[r] = (mem_q[r] & ~alu_bmask) | (alu_wdata & alu_bmask);
            end
            if (commit_hit && (commit_addr == AW'(r))) begin
                mem_d[r] = commit_data;
            end
        end
    end

    // Busy scoreboard: set when a load is accepted, cleared by its commit
    always_comb begin
        busy_d = busy_q;
        if (commit_hit) begin
            busy_d[commit_addr] = 1'b0;
        end
        if (ld_start && ld_ready && (32'(ld_addr) < NUM_REGS)) begin
            busy_d[ld_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign raddr_c[0] = raddr1;
    assign raddr_c[1] = raddr2;
    assign raddr_c[2] = raddr3;

    // Read ports; busy is never bypassed, so a committing register still reads busy
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            rdata_c[p] = '0;
            rbusy_c[p] = 1'b0;
            if (32'(raddr_c[p]) < NUM_REGS) begin
                rdata_c[p] = (BYPASS != 0) ? mem_d[raddr_c[p]] : mem_q[raddr_c[p]];
                rbusy_c[p] = busy_q[raddr_c[p]];
            end
        end
    end

    assign rdata1 = rdata_c[0];
    assign rdata2 = rdata_c[1];
    assign rdata3 = rdata_c[2];
    assign rbusy1 = rbusy_c[0];
    assign rbusy2 = rbusy_c[1];
    assign rbusy3 = rbusy_c[2];

endmodule

// File: tb/tb_cv32e40p_vreg_file_ld.sv
// Bench for cv32e40p_vreg_file_ld. Two instances share every input:
//   u_dut_b : 16 registers, BYPASS=1
//   u_dut_n : 11 registers, BYPASS=0 (addresses 11..15 out of range)
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_cv32e40p_vreg_file_ld;

    logic         clk = 1'b0;
    logic         rst;
    logic         alu_we;
    logic [3:0]   alu_waddr;
    logic [127:0] alu_wdata;
    logic [3:0]   alu_wmask;
    logic         ld_start;
    logic [3:0]   ld_addr;
    logic         ld_beat_valid;
    logic [31:0]  ld_beat_data;
    logic [3:0]   raddr1, raddr2, raddr3;

    logic         ld_ready_b, ld_done_b, wr_conflict_b, rbusy1_b, rbusy2_b, rbusy3_b;
    logic [127:0] rdata1_b, rdata2_b, rdata3_b;
    logic         ld_ready_n, ld_done_n, wr_conflict_n, rbusy1_n, rbusy2_n, rbusy3_n;
    logic [127:0] rdata1_n, rdata2_n, rdata3_n;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt_b = 0, done_cnt_n = 0, conf_cnt_b = 0, conf_cnt_n = 0;

    // Reference register images
    logic [127:0] mb [16];
    logic [127:0] mn [16];

    // Scoreboard of expected rdata1 values (bypass instance, no-bypass instance)
    string        tag_q [$];
    logic [127:0] eb_q  [$];
    logic [127:0] en_q  [$];

    always #5 clk = ~clk;

    cv32e40p_vreg_file_ld #(.NUM_REGS(16), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_wmask(alu_wmask),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_ready(ld_ready_b),
        .ld_beat_valid(ld_beat_valid), .ld_beat_data(ld_beat_data),
        .ld_done(ld_done_b), .wr_conflict(wr_conflict_b),
        .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .rdata3(rdata3_b),
        .rbusy1(rbusy1_b), .rbusy2(rbusy2_b), .rbusy3(rbusy3_b)
    );

    cv32e40p_vreg_file_ld #(.NUM_REGS(11), .BYPASS(0)) u_dut_n (
        .clk(clk), .rst(rst),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_wmask(alu_wmask),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_ready(ld_ready_n),
        .ld_beat_valid(ld_beat_valid), .ld_beat_data(ld_beat_data),
        .ld_done(ld_done_n), .wr_conflict(wr_conflict_n),
        .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
        .rdata1(rdata1_n), .rdata2(rdata2_n), .rdata3(rdata3_n),
        .rbusy1(rbusy1_n), .rbusy2(rbusy2_n), .rbusy3(rbusy3_n)
    );

    // Pulse counters
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ld_done_b === 1'b1)     done_cnt_b++;
            if (ld_done_n === 1'b1)     done_cnt_n++;
            if (wr_conflict_b === 1'b1) conf_cnt_b++;
            if (wr_conflict_n === 1'b1) conf_cnt_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        tick();
        alu_we        = 1'b0;
        ld_start      = 1'b0;
        ld_beat_valid = 1'b0;
    endtask

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                           input logic [3:0] m);
        logic [127:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) r[l*32 +: 32] = d[l*32 +: 32];
        end
        return r;
    endfunction

    function automatic logic [127:0] rd_b(input logic [3:0] a);
        return mb[a];
    endfunction

    function automatic logic [127:0] rd_n(input logic [3:0] a);
        return (a < 4'd11) ? mn[a] : 128'h0;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 16; r++) begin
            mb[r] = '0;
            mn[r] = '0;
        end
    endtask

    task automatic m_alu(input logic [3:0] a, input logic [127:0] d, input logic [3:0] m);
        mb[a] = merge(mb[a], d, m);
        if (a < 4'd11) mn[a] = merge(mn[a], d, m);
    endtask

    task automatic m_commit(input logic [3:0] a, input logic [127:0] v);
        mb[a] = v;
        if (a < 4'd11) mn[a] = v;
    endtask

    task automatic sb_push(input string tag, input logic [127:0] eb, input logic [127:0] en);
        tag_q.push_back(tag);
        eb_q.push_back(eb);
        en_q.push_back(en);
    endtask

    task automatic sb_pop();
        string        t;
        logic [127:0] eb, en;
        if (tag_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            t  = tag_q.pop_front();
            eb = eb_q.pop_front();
            en = en_q.pop_front();
            check({t, "_rd_b"}, rdata1_b, eb);
            check({t, "_rd_n"}, rdata1_n, en);
        end
    endtask

    // ALU write with raddr1 on the written register (bypass visible on _b only)
    task automatic alu_cycle(input string tag, input logic [3:0] a, input logic [127:0] d,
                             input logic [3:0] m);
        logic [127:0] old_n;
        alu_we = 1'b1; alu_waddr = a; alu_wdata = d; alu_wmask = m; raddr1 = a;
        old_n = rd_n(a);
        m_alu(a, d, m);
        sb_push(tag, rd_b(a), old_n);
        @(negedge clk);
        sb_pop();
    endtask

    task automatic idle_rd(input string tag, input logic [3:0] a);
        raddr1 = a;
        sb_push(tag, rd_b(a), rd_n(a));
        @(negedge clk);
        sb_pop();
    endtask

    // Start cycle plus LANES beats; returns at the start of the COMMIT cycle
    task automatic run_load(input logic [3:0] a, input logic [127:0] vec, input int gap,
                            input bit alu_mid);
        ld_start = 1'b1; ld_addr = a; ld_beat_valid = 1'b1; ld_beat_data = 32'hBAD0BAD0;
        raddr1 = a; raddr2 = 4'd9;
        @(negedge clk);
        check("ld_ready_idle_b", 128'(ld_ready_b), 128'(1));
        check("ld_ready_idle_n", 128'(ld_ready_n), 128'(1));
        check("busy_start_b", 128'(rbusy1_b), 128'(0));
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_we = 1'b0;
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    ld_beat_valid = 1'b0; ld_start = 1'b1; ld_addr = 4'd9;
                    @(negedge clk);
                    check("gap_ready_b", 128'(ld_ready_b), 128'(0));
                    check("gap_busy_b", 128'(rbusy1_b), 128'(1));
                    check("gap_busy_n", 128'(rbusy1_n), 128'(a < 4'd11));
                    check("gap_busy9_b", 128'(rbusy2_b), 128'(0));
                    check("gap_busy9_n", 128'(rbusy2_n), 128'(0));
                    tick();
                end
                ld_start = 1'b0;
            end
            if (i == 1 && alu_mid) begin
                alu_we = 1'b1; alu_waddr = a; alu_wdata = {4{32'h66666666}}; alu_wmask = 4'hF;
            end
            if (i == 2 && alu_mid) sb_push("alu_busy", rd_b(a), rd_n(a));
            ld_beat_valid = 1'b1;
            ld_beat_data  = vec[i*32 +: 32];
            @(negedge clk);
            if (i == 2 && alu_mid) sb_pop();
            check("beat_ready_b", 128'(ld_ready_b), 128'(0));
            check("beat_ready_n", 128'(ld_ready_n), 128'(0));
            check("beat_busy_b", 128'(rbusy1_b), 128'(1));
            check("beat_busy_n", 128'(rbusy1_n), 128'(a < 4'd11));
            tick();
            if (i == 1 && alu_mid) m_alu(a, {4{32'h66666666}}, 4'hF);
        end
        alu_we = 1'b0;
        ld_beat_valid = 1'b0;
    endtask

    // COMMIT cycle with an optional concurrent ALU write (raddr2 watches its target)
    task automatic commit_cycle(input string tag, input logic [3:0] a, input logic [127:0] vec,
                                input bit alu_en, input logic [3:0] alu_a,
                                input logic [127:0] alu_d, input bit exp_conf);
        logic [127:0] old_n, old_n2;
        alu_we = alu_en; alu_waddr = alu_a; alu_wdata = alu_d; alu_wmask = 4'hF;
        raddr1 = a; raddr2 = alu_a;
        old_n  = rd_n(a);
        old_n2 = rd_n(alu_a);
        if (alu_en && !exp_conf) m_alu(alu_a, alu_d, 4'hF);
        m_commit(a, vec);
        sb_push(tag, rd_b(a), old_n);
        @(negedge clk);
        sb_pop();
        check({tag, "_done_b"}, 128'(ld_done_b), 128'(1));
        check({tag, "_done_n"}, 128'(ld_done_n), 128'(1));
        check({tag, "_ready_b"}, 128'(ld_ready_b), 128'(0));
        check({tag, "_conf_b"}, 128'(wr_conflict_b), 128'(exp_conf));
        check({tag, "_conf_n"}, 128'(wr_conflict_n), 128'(exp_conf));
        check({tag, "_busy_b"}, 128'(rbusy1_b), 128'(1));
        check({tag, "_busy_n"}, 128'(rbusy1_n), 128'(a < 4'd11));
        check({tag, "_rd2_b"}, rdata2_b, rd_b(alu_a));
        check({tag, "_rd2_n"}, rdata2_n, old_n2);
        next_cycle();
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            raddr3 = 4'(15 - i);
            idle_rd(tag, 4'(i));
            check({tag, "_rd3_b"}, rdata3_b, rd_b(4'(15 - i)));
            check({tag, "_rd3_n"}, rdata3_n, rd_n(4'(15 - i)));
            check({tag, "_busy3_b"}, 128'(rbusy3_b), 128'(0));
            check({tag, "_busy3_n"}, 128'(rbusy3_n), 128'(0));
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0; alu_wmask = '0;
        ld_start = 1'b0; ld_addr = '0; ld_beat_valid = 1'b0; ld_beat_data = '0;
        raddr1 = '0; raddr2 = '0; raddr3 = '0;
        m_reset();

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_ready_b", 128'(ld_ready_b), 128'(1));
        check("rst_ready_n", 128'(ld_ready_n), 128'(1));
        check("rst_done_b", 128'(ld_done_b), 128'(0));
        check("rst_conf_b", 128'(wr_conflict_b), 128'(0));
        check("rst_busy_b", 128'(rbusy1_b), 128'(0));
        check("rst_busy_n", 128'(rbusy1_n), 128'(0));
        check("rst_rd_b", rdata1_b, 128'h0);
        check("rst_rd_n", rdata1_n, 128'h0);
        tick();
        rst = 1'b0;

        // Masked merge
        alu_cycle("preload3", 4'd3, 128'h44443333_22221111_00000000_FFFFFFFF, 4'hF);
        next_cycle();
        alu_cycle("merge3", 4'd3, {4{32'hAAAAAAAA}}, 4'b0101);
        check("merge3_lit_b", rdata1_b, 128'h44443333_AAAAAAAA_00000000_AAAAAAAA);
        next_cycle();
        alu_cycle("mask0", 4'd3, {4{32'hFFFFFFFF}}, 4'b0000);
        check("mask0_lit_n", rdata1_n, 128'h44443333_AAAAAAAA_00000000_AAAAAAAA);
        next_cycle();

        // Same-cycle bypass on a single lane
        alu_cycle("byp2", 4'd2, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 4'b0010);
        check("byp2_lane1_b", 128'(rdata1_b[63:32]), 128'h0DEADBEEF);
        check("byp2_lane1_n", 128'(rdata1_n[63:32]), 128'h0);
        next_cycle();
        idle_rd("byp2_next", 4'd2);
        check("byp2_next_lane1_n", 128'(rdata1_n[63:32]), 128'h0DEADBEEF);
        next_cycle();

        // Load with gaps
        run_load(4'd5, 128'h00000044_00000033_00000022_00000011, 3, 1'b0);
        commit_cycle("ld5", 4'd5, 128'h00000044_00000033_00000022_00000011, 1'b0, 4'd0, '0, 1'b0);
        idle_rd("ld5_after", 4'd5);
        check("ld5_lit_b", rdata1_b, 128'h00000044_00000033_00000022_00000011);
        check("ld5_lit_n", rdata1_n, 128'h00000044_00000033_00000022_00000011);
        check("ld5_busy_after_b", 128'(rbusy1_b), 128'(0));
        check("ld5_busy_after_n", 128'(rbusy1_n), 128'(0));
        check("ld5_ready_after_b", 128'(ld_ready_b), 128'(1));
        check("ld5_done_after_b", 128'(ld_done_b), 128'(0));
        next_cycle();

        // Collision: load wins
        run_load(4'd7, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1, 0, 1'b0);
        commit_cycle("col7", 4'd7, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1, 1'b1, 4'd7,
                     {4{32'h55555555}}, 1'b1);
        idle_rd("col7_after", 4'd7);
        check("col7_lit_n", rdata1_n, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1);
        check("col7_conf_after_b", 128'(wr_conflict_b), 128'(0));
        next_cycle();

        // Commit and ALU to different registers; ALU write to a busy register mid-load
        run_load(4'd7, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 1, 1'b1);
        commit_cycle("nocol", 4'd7, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 1'b1, 4'd8,
                     {4{32'h77777777}}, 1'b0);
        raddr2 = 4'd8;
        idle_rd("nocol_after", 4'd7);
        check("nocol_r8_b", rdata2_b, {4{32'h77777777}});
        check("nocol_r8_n", rdata2_n, {4{32'h77777777}});
        check("nocol_r7_lit_n", rdata1_n, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1);
        next_cycle();

        // Reset in the middle of a load
        ld_start = 1'b1; ld_addr = 4'd6;
        tick();
        ld_start = 1'b0; ld_beat_valid = 1'b1; ld_beat_data = 32'h1;
        tick();
        ld_beat_data = 32'h2;
        tick();
        rst = 1'b1; ld_beat_data = 32'h3;
        tick();
        rst = 1'b0; ld_beat_valid = 1'b0;
        m_reset();
        raddr1 = 4'd6;
        @(negedge clk);
        check("rstmid_ready_b", 128'(ld_ready_b), 128'(1));
        check("rstmid_ready_n", 128'(ld_ready_n), 128'(1));
        check("rstmid_busy_b", 128'(rbusy1_b), 128'(0));
        check("rstmid_busy_n", 128'(rbusy1_n), 128'(0));
        tick();
        sweep("rstmid");

        // Full load after reset
        run_load(4'd6, 128'h06060606_06060604_06060602_06060601, 0, 1'b0);
        commit_cycle("ld6", 4'd6, 128'h06060606_06060604_06060602_06060601, 1'b0, 4'd0, '0, 1'b0);
        idle_rd("ld6_after", 4'd6);
        next_cycle();

        // Out-of-range addresses on the 11-register instance
        alu_cycle("oor12", 4'd12, {4{32'h12121212}}, 4'hF);
        check("oor12_busy_n", 128'(rbusy1_n), 128'(0));
        check("oor12_busy_b", 128'(rbusy1_b), 128'(0));
        next_cycle();
        idle_rd("oor12_next", 4'd12);
        check("oor12_lit_n", rdata1_n, 128'h0);
        next_cycle();
        run_load(4'd13, 128'h13131313_13131312_13131311_13131310, 1, 1'b0);
        commit_cycle("ld13", 4'd13, 128'h13131313_13131312_13131311_13131310, 1'b0, 4'd0, '0, 1'b0);
        sweep("final");

        check("done_count_b", 128'(done_cnt_b), 128'(5));
        check("done_count_n", 128'(done_cnt_n), 128'(5));
        check("conf_count_b", 128'(conf_cnt_b), 128'(1));
        check("conf_count_n", 128'(conf_cnt_n), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_vreg_file_ld.md
Name: cv32e40p_vreg_file_ld

Overview:
- Parametrised vector register file for the CNN vector extension: NUM_REGS registers of LANES x LANE_W bits, three combinational read ports, one lane-masked ALU write port.
- Adds a beat-serial load port that assembles LANES words from the LSU into one register write.
- Adds a per-register busy scoreboard so the decoder can stall on pending loads.
- Sits beside the integer regfile in the ID stage.
- Masked writes merge: unmasked lanes keep their old value; they are not zeroed.

Parameters:
- NUM_REGS, 16, number of vector registers.
- LANES, 4, lanes per register.
- LANE_W, 32, bits per lane; also the load beat width.
- BYPASS, 1, when 1 read ports forward same-cycle write data.
- AW, $clog2(NUM_REGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_we  in  1  ALU write enable.
- alu_waddr  in  AW  ALU write register.
- alu_wdata  in  LANES*LANE_W  ALU write data; lane i is bits [i*LANE_W +: LANE_W].
- alu_wmask  in  LANES  per-lane write enable.
- ld_start  in  1  request load into ld_addr.
- ld_addr  in  AW  load destination register.
- ld_ready  out  1  load sequencer idle; ld_start is accepted only when high.
- ld_beat_valid  in  1  LSU beat valid.
- ld_beat_data  in  LANE_W  beat payload; lane 0 arrives first.
- ld_done  out  1  one-cycle pulse, high in the commit cycle.
- wr_conflict  out  1  one-cycle pulse when an ALU write is dropped.
- raddr1/2/3  in  AW  read addresses.
- rdata1/2/3  out  LANES*LANE_W  read data.
- rbusy1/2/3  out  1  addressed register has a pending load.

Behaviour:
- Reset: all registers 0, busy 0, sequencer in IDLE, beat count 0. Resulting outputs: ld_ready=1, ld_done=0, wr_conflict=0, rbusy*=0, rdata*=0.
- Reset mid-load aborts the load: no commit, busy cleared.
- ALU write: if alu_we=1, each lane i with alu_wmask[i]=1 is updated at the clock edge; other lanes keep their value. mask=0 is a no-op.
- Load sequencer states: IDLE, COLLECT, COMMIT.
  - IDLE -> COLLECT on ld_start: latch ld_addr, set busy[ld_addr], clear beat count.
  - COLLECT: each cycle with ld_beat_valid=1 stores the beat into lane[count] and increments count. Gaps (valid=0) are allowed indefinitely. After lane LANES-1 is captured, go to COMMIT.
  - COMMIT (exactly 1 cycle): write the full assembled vector (all lanes) to the latched register, clear its busy bit, assert ld_done, return to IDLE.
  - ld_ready=1 only in IDLE. ld_start in other states is ignored. ld_beat_valid outside COLLECT is ignored.
  - Minimum latency: ld_start at cycle 0, beats in cycles 1..LANES, COMMIT in cycle LANES+1. Data is readable in cycle LANES+2, or in cycle LANES+1 when BYPASS=1.
  - A beat arriving in the same cycle as ld_start is ignored.
- Write collision (COMMIT and alu_we to the same register in the same cycle): load wins; the ALU write is dropped entirely; wr_conflict=1 that cycle. Commit and ALU write to different registers both complete.
- ALU write to a busy register outside COMMIT: performed. A later COMMIT overwrites it.
- Reads are combinational. BYPASS=1: if the read address equals a register written this cycle, rdata shows the post-write (merged) value. BYPASS=0: rdata shows the pre-edge contents.
- rbusyN is combinational from busy[raddrN]. There is no bypass on busy: a register being committed still reads busy=1 in the COMMIT cycle.
- Addresses >= NUM_REGS: writes ignored; reads return 0 with rbusy=0. ld_start to such an address still runs the sequence, but the commit is discarded.

Decomposition:
- Package cv32e40p_vreg_pkg holds: state enum {IDLE, COLLECT, COMMIT}; default constants VREG_NUM_REGS=16, VREG_LANES=4, VREG_LANE_W=32; lane-mask expansion function (LANES bits -> LANES*LANE_W bit mask).
- Sub-module cv32e40p_vreg_ld_assembler: FSM, beat counter, assembly buffer, latched address. Outputs a commit strobe, address and data to the array top.
- Top level holds: array, scoreboard, write arbitration, bypass muxes.

Test Plan:
- Masked merge: reg3=0x44443333_22221111_00000000_FFFFFFFF; ALU write 0xAAAAAAAA in all lanes with mask 4'b0101 -> reg3=0x44443333_AAAAAAAA_00000000_AAAAAAAA.
- Load with gaps: ld_start to reg5, beats 0x11,0x22 then 3 idle cycles, then 0x33,0x44.
  - ld_ready=0 throughout; rbusy for reg5 =1 until after COMMIT.
  - ld_done pulses once.
  - reg5=0x00000044_00000033_00000022_00000011.
- Collision: in the COMMIT cycle to reg7, alu_we to reg7 with mask 4'hF -> reg7 holds load data; wr_conflict=1 for 1 cycle. Repeat with ALU write to reg8 -> both registers written, wr_conflict=0.
- Bypass: BYPASS=1, ALU writes reg2 lane1=0xDEADBEEF with raddr1=2 in the same cycle -> rdata1 lane1=0xDEADBEEF in that cycle. BYPASS=0 -> old value that cycle, new value next cycle.
- Reset mid-load: rst asserted after 2 of 4 beats -> ld_ready=1, rbusy*=0, all registers 0. A subsequent full load completes normally.
- Out-of-range: NUM_REGS=11, ALU write to addr 12 -> no register changes; raddr1=12 -> rdata1=0, rbusy1=0.
